// File: rtl/reg_pc_unit_pkg.sv
// ----------------------------------------------------------------------------
//  reg_pc_unit_pkg : vector constants and shared types for the 6502 PC unit
//  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package reg_pc_unit_pkg;

   localparam int          PC_HALF_W_DEF = 8;
   localparam logic [15:0] VEC_NMI       = 16'hFFFA;
   localparam logic [15:0] VEC_RESET     = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ       = 16'hFFFE;

   typedef enum logic {
      DB_SRC_PCL = 1'b0,
      DB_SRC_PCH = 1'b1
   } db_src_e;

endpackage : reg_pc_unit_pkg

`default_nettype wire

// File: rtl/reg_pc_unit_half.sv
// ----------------------------------------------------------------------------
//  pc_half : one PC half - register, source mux, +cin incrementer, carry-out
//  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_half #(
   parameter int               W       = 8,
   parameter logic [W-1:0]     RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         cin,
   output logic [W-1:0] q,
   output logic         cout
);

   logic [W-1:0] src;
   logic [W-1:0] nxt;

   assign src  = load ? load_data : q;
   assign nxt  = src + {{(W-1){1'b0}}, cin};
   // Carry leaves this half only when the selected source is all-ones.
   assign cout = cin & (&src);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= nxt;
      end
   end

endmodule : pc_half

`default_nettype wire

// File: rtl/reg_pc_unit.sv
// ----------------------------------------------------------------------------
//  reg_pc_unit : clocked 6502 program counter with optional split carry
//  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_pc_unit
   import reg_pc_unit_pkg::*;
#(
   parameter int                      HALF_W       = PC_HALF_W_DEF,
   parameter logic [2*HALF_W-1:0]     RESET_VECTOR = (2*HALF_W)'(VEC_RESET),
   parameter bit                      SPLIT_CARRY  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_write,
   input  logic                  inc,
   input  logic                  adl_load,
   input  logic                  adh_load,
   input  logic [HALF_W-1:0]     adl_data,
   input  logic [HALF_W-1:0]     adh_data,
   input  logic                  db_en,
   input  logic                  db_sel_pch,
   input  logic                  adl_en,
   input  logic                  adh_en,
   output logic [HALF_W-1:0]     db_bus,
   output logic [HALF_W-1:0]     adl_bus,
   output logic [HALF_W-1:0]     adh_bus,
   output logic [2*HALF_W-1:0]   pc_out,
   output logic                  carry_pending
);

   logic [HALF_W-1:0] pcl;
   logic [HALF_W-1:0] pch;
   logic              c_lo;
   logic              hi_cin;
   logic              pch_cout_unused;
   db_src_e           db_src;

   pc_half #(
      .W       (HALF_W),
      .RST_VAL (RESET_VECTOR[HALF_W-1:0])
   ) u_pcl (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pc_write),
      .load      (adl_load),
      .load_data (adl_data),
      .cin       (inc),
      .q         (pcl),
      .cout      (c_lo)
   );

   pc_half #(
      .W       (HALF_W),
      .RST_VAL (RESET_VECTOR[2*HALF_W-1:HALF_W])
   ) u_pch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pc_write),
      .load      (adh_load),
      .load_data (adh_data),
      .cin       (hi_cin),
      .q         (pch),
      .cout      (pch_cout_unused)
   );

   generate
      if (SPLIT_CARRY) begin : g_split
         logic pend;

         // A fresh page load discards the carry owed to the old page.
         assign hi_cin = pend & ~adh_load;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pend <= 1'b0;
            end else if (pc_write) begin
               pend <= c_lo;
            end
         end

         assign carry_pending = pend;
      end else begin : g_same
         assign hi_cin        = c_lo;
         assign carry_pending = 1'b0;
      end
   endgenerate

   assign db_src  = db_src_e'(db_sel_pch);
   assign db_bus  = !db_en  ? '0 : ((db_src == DB_SRC_PCH) ? pch : pcl);
   assign adl_bus = adl_en  ? pcl : '0;
   assign adh_bus = adh_en  ? pch : '0;
   assign pc_out  = {pch, pcl};

endmodule : reg_pc_unit

`default_nettype wire

// File: tb/tb_reg_pc_unit.sv
// ----------------------------------------------------------------------------
//  tb_reg_pc_unit : scoreboard bench for split- and same-cycle-carry PC units
//  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_pc_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pc_write, inc, adl_load, adh_load;
   logic [7:0] adl_data, adh_data;
   logic       db_en, db_sel_pch, adl_en, adh_en;

   logic [7:0]  db_s, adl_s, adh_s, db_n, adl_n, adh_n;
   logic [15:0] pc_s, pc_n;
   logic        pend_s, pend_n;

   always #5 clk = ~clk;

   reg_pc_unit #(.HALF_W(8), .RESET_VECTOR(16'hFFFC), .SPLIT_CARRY(1'b1)) u_split (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .inc(inc),
      .adl_load(adl_load), .adh_load(adh_load), .adl_data(adl_data), .adh_data(adh_data),
      .db_en(db_en), .db_sel_pch(db_sel_pch), .adl_en(adl_en), .adh_en(adh_en),
      .db_bus(db_s), .adl_bus(adl_s), .adh_bus(adh_s), .pc_out(pc_s), .carry_pending(pend_s)
   );

   reg_pc_unit #(.HALF_W(8), .RESET_VECTOR(16'hFFFC), .SPLIT_CARRY(1'b0)) u_same (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .inc(inc),
      .adl_load(adl_load), .adh_load(adh_load), .adl_data(adl_data), .adh_data(adh_data),
      .db_en(db_en), .db_sel_pch(db_sel_pch), .adl_en(adl_en), .adh_en(adh_en),
      .db_bus(db_n), .adl_bus(adl_n), .adh_bus(adh_n), .pc_out(pc_n), .carry_pending(pend_n)
   );

   typedef struct {
      string       tag;
      logic [15:0] pc_s;
      logic        pend_s;
      logic [15:0] pc_n;
      logic [7:0]  db_s, adl_s, adh_s;
      logic [7:0]  db_n, adl_n, adh_n;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: split model keeps the owed page carry as a plain flag,
   // same-cycle model is simply a 16-bit counter.
   logic [15:0] m_pc_s = 16'hFFFC;
   logic        m_pend = 1'b0;
   logic [15:0] m_pc_n = 16'hFFFC;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] bus_db(input logic [15:0] pc, input logic en, input logic sel);
      return !en ? 8'h00 : (sel ? pc[15:8] : pc[7:0]);
   endfunction

   function automatic exp_t make_exp(input string tag);
      exp_t e;
      e.tag    = tag;
      e.pc_s   = m_pc_s;
      e.pend_s = m_pend;
      e.pc_n   = m_pc_n;
      e.db_s   = bus_db(m_pc_s, db_en, db_sel_pch);
      e.adl_s  = adl_en ? m_pc_s[7:0]  : 8'h00;
      e.adh_s  = adh_en ? m_pc_s[15:8] : 8'h00;
      e.db_n   = bus_db(m_pc_n, db_en, db_sel_pch);
      e.adl_n  = adl_en ? m_pc_n[7:0]  : 8'h00;
      e.adh_n  = adh_en ? m_pc_n[15:8] : 8'h00;
      return e;
   endfunction

   task automatic apply(input string tag, input logic pw, input logic in_c,
                        input logic al, input logic ah, input logic [7:0] dl, input logic [7:0] dh,
                        input logic dbe, input logic dbs, input logic ale, input logic ahe);
      logic [7:0]  src_lo, src_hi;
      logic [15:0] src_n;
      @(negedge clk);
      rst_n = 1'b1;
      pc_write = pw; inc = in_c; adl_load = al; adh_load = ah;
      adl_data = dl; adh_data = dh;
      db_en = dbe; db_sel_pch = dbs; adl_en = ale; adh_en = ahe;
      if (pw) begin
         src_lo = al ? dl : m_pc_s[7:0];
         src_hi = ah ? dh : m_pc_s[15:8];
         m_pc_s = {src_hi + 8'((m_pend && !ah) ? 1 : 0), src_lo + 8'(in_c)};
         m_pend = in_c && (src_lo == 8'hFF);
         src_n  = {(ah ? dh : m_pc_n[15:8]), (al ? dl : m_pc_n[7:0])};
         m_pc_n = src_n + 16'(in_c);
      end
      q.push_back(make_exp(tag));
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      pc_write = 1'b1; inc = 1'b1;
      db_en = 1'b0; adl_en = 1'b0; adh_en = 1'b0; db_sel_pch = 1'b0;
      m_pc_s = 16'hFFFC; m_pend = 1'b0; m_pc_n = 16'hFFFC;
      #1;
      chk({tag, "_async_pc_split"}, pc_s, 16'hFFFC);
      chk({tag, "_async_pend"},     {15'd0, pend_s}, 16'd0);
      chk({tag, "_async_pc_same"},  pc_n, 16'hFFFC);
      chk({tag, "_async_buses"},    {db_s | adl_s | adh_s, db_n | adl_n | adh_n}, 16'd0);
      q.push_back(make_exp({tag, "_held"}));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_pc_split"}, pc_s, e.pc_s);
            chk({e.tag, "_pend_split"}, {15'd0, pend_s}, {15'd0, e.pend_s});
            chk({e.tag, "_pc_same"}, pc_n, e.pc_n);
            chk({e.tag, "_pend_same"}, {15'd0, pend_n}, 16'd0);
            chk({e.tag, "_db_split"}, {8'd0, db_s}, {8'd0, e.db_s});
            chk({e.tag, "_adl_adh_split"}, {adh_s, adl_s}, {e.adh_s, e.adl_s});
            chk({e.tag, "_db_same"}, {8'd0, db_n}, {8'd0, e.db_n});
            chk({e.tag, "_adl_adh_same"}, {adh_n, adl_n}, {e.adh_n, e.adl_n});
         end
      end
   end

   initial begin : driver
      int budget;
      rst_n = 1'b0; pc_write = 1'b0; inc = 1'b0; adl_load = 1'b0; adh_load = 1'b0;
      adl_data = 8'h00; adh_data = 8'h00;
      db_en = 1'b0; db_sel_pch = 1'b0; adl_en = 1'b0; adh_en = 1'b0;

      do_reset("por");
      apply("idle", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

      // Split carry walk across a page boundary.
      apply("ld10FE", 1, 0, 1, 1, 8'hFE, 8'h10, 0, 0, 0, 0);
      apply("inc10FF", 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      apply("inc1000", 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      apply("fix1100", 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

      // Full-width wrap and carry into PCH.
      apply("ldFFFF", 1, 0, 1, 1, 8'hFF, 8'hFF, 0, 0, 0, 0);
      apply("wrap", 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      apply("wrapfix", 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

      // Jump with increment, then the same inputs with PC_WRITE low.
      apply("jump", 1, 1, 1, 1, 8'h34, 8'h12, 0, 0, 0, 0);
      apply("hold", 0, 1, 1, 1, 8'h34, 8'h12, 0, 0, 0, 0);

      // Page load colliding with a pending carry.
      apply("ld20FF", 1, 0, 1, 1, 8'hFF, 8'h20, 0, 0, 0, 0);
      apply("pend", 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      apply("collide", 1, 0, 1, 1, 8'h05, 8'h40, 0, 0, 0, 0);

      // Load plus carry-generating increment while the page is loaded.
      apply("ld30FF", 1, 0, 1, 1, 8'hFF, 8'h30, 0, 0, 0, 0);
      apply("pend2", 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      apply("collide_new", 1, 1, 1, 1, 8'hFF, 8'h50, 0, 0, 0, 0);
      apply("collide_fix", 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

      // Bus drivers.
      apply("ldABCD", 1, 0, 1, 1, 8'hCD, 8'hAB, 0, 0, 0, 0);
      apply("db_pch", 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
      apply("db_pcl", 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
      apply("adl_en", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
      apply("adh_en", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
      apply("all_off", 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);

      // Reset while a carry is owed.
      apply("ld40FF", 1, 0, 1, 1, 8'hFF, 8'h40, 1, 1, 1, 1);
      apply("pend3", 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1);
      do_reset("midrst");

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset("rnd_rst");
         end else begin
            apply("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected responses never observed, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_pc_unit

`default_nettype wire
